trng_serial_tx: RTL

Byte-stream serial back end of the TRNG: buffers bytes from the entropy/conditioning pipeline in a small FIFO and shifts them out as 8N1 UART frames on `o_serial_data`, obeying the host's active-low RTS flow control. Sits directly downstream of the conditioner inside `trng_top` and drives the board-level serial pin. It also exports a byte-sent activity counter used to drive the breakout LEDs.

---
 rtl/trng_serial_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/trng_serial_tx.sv
// TRNG serial back end: byte FIFO feeding an 8N1 UART transmitter gated by host RTS.
// Frames start only when the FIFO holds data and the synchronised RTS is asserted.
module trng_serial_tx #(
  parameter int unsigned BAUD_DIV = 96,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_dat,
  input  logic               i_dat_valid,
  output logic               o_dat_ready,
  input  logic               i_serial_rts_n,
  output logic               o_serial_data,
  output logic [3:0]         o_dat_cnt,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic               o_busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;
  localparam logic [15:0] BitLast = 16'(BAUD_DIV - 1);

  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic [FIFO_AW:0]   level_d;
  logic               rts_meta_q;
  logic               rts_sync_q;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [15:0]        timer_q;
  logic [15:0]        timer_d;
  logic [2:0]         bit_idx_q;
  logic [2:0]         bit_idx_d;
  logic [7:0]         shift_q;
  logic [7:0]         shift_d;
  logic               line_q;
  logic               line_d;
  logic [3:0]         cnt_q;
  logic [3:0]         cnt_d;
  logic               full;
  logic               empty;
  logic               go;
  logic               push;
  logic               pop;
  logic               bit_end;

  // Level never exceeds the depth, so its MSB alone marks the full condition.
  assign full    = level_q[FIFO_AW];
  assign empty   = (level_q == '0);
  assign go      = ~empty & ~rts_sync_q;
  assign push    = i_dat_valid & o_dat_ready;
  assign bit_end = (timer_q == BitLast);

  // The line is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        line_d  = 1'b1;
        timer_d = '0;
        if (go) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          line_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = StData;
          line_d    = shift_q[0];
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            line_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            line_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          cnt_d   = cnt_q + 4'd1;
          if (go) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
            line_d  = 1'b0;
          end else begin
            state_d = StIdle;
            line_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rts_meta_q <= 1'b1;
      rts_sync_q <= 1'b1;
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      line_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      level_q    <= level_d;
      rts_meta_q <= i_serial_rts_n;
      rts_sync_q <= rts_meta_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_dat_ready   = ~full & ~i_reset;
  assign o_serial_data = line_q;
  assign o_dat_cnt     = cnt_q;
  assign o_fifo_level  = level_q;
  assign o_busy        = (state_q != StIdle);

endmodule
